mem_dump: RTL
=============

MEM_DUMP -- requirements
Module: mem_dump

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, the word-address width of the memory being dumped.
REQ-002 SHALL have parameter DATA_W, default 32, the memory word width.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port start  input  1  request to begin a dump; sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  ADDR_W  first word address, sampled with start.
REQ-007 SHALL have port word_count  input  ADDR_W+1  number of words to dump (0..2^ADDR_W), sampled with start.
REQ-008 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse at dump completion.
REQ-010 SHALL have port mem_rd_en  output  1  synchronous read strobe to the data memory.
REQ-011 SHALL have port mem_addr  output  ADDR_W  read address; valid while mem_rd_en is high.
REQ-012 SHALL have port mem_rd_data  input  DATA_W  read data, valid the cycle after mem_rd_en.
REQ-013 SHALL have port out_valid  output  1  out_data, out_addr and out_last are valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-015 SHALL have port out_data  output  DATA_W  dumped word.
REQ-016 SHALL have port out_addr  output  ADDR_W  memory address of out_data.
REQ-017 SHALL have port out_last  output  1  high with the final word of a dump.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, WAIT, SEND, FIN; all outputs registered or decoded from state only.
REQ-019 IDLE: start=1 with word_count>0 -> latch base_addr and word_count, go to REQ; start=1 with word_count=0 -> FIN; otherwise stay.
REQ-020 REQ (1 cycle): mem_rd_en=1, mem_addr = base_addr + index, with index starting at 0; then go to WAIT.
REQ-021 WAIT (1 cycle): capture mem_rd_data, mem_addr and (remaining==1) into the output registers at the end of the cycle; then go to SEND.
REQ-022 SEND: out_valid=1; out_data, out_addr and out_last SHALL stay stable until out_valid&&out_ready at a rising edge.
REQ-023 On transfer in SEND, decrement remaining and increment index; if out_last was 1 go to FIN, else go to REQ.
REQ-024 FIN (1 cycle): done=1, busy=0; then go to IDLE.
REQ-025 busy SHALL be 1 in REQ, WAIT and SEND, and 0 in IDLE and FIN.
REQ-026 Latency: start sampled at edge E0 -> mem_rd_en high in the cycle after E0; first out_valid high 2 cycles later; steady-state rate is one word per 3 cycles with out_ready held high.
REQ-027 Address arithmetic SHALL be modulo 2^ADDR_W; a dump SHALL wrap from address 2^ADDR_W-1 to address 0.
REQ-028 word_count = 2^ADDR_W SHALL dump every word exactly once.
REQ-029 start asserted outside IDLE SHALL be ignored and SHALL NOT alter the latched parameters.
REQ-030 mem_rd_en SHALL never be asserted outside REQ; exactly word_count reads SHALL be issued per dump.
REQ-031 out_valid SHALL NOT drop before a transfer, regardless of how long out_ready is held low.

Reset
REQ-032 reset=0 SHALL immediately force state IDLE, busy=0, done=0, mem_rd_en=0, mem_addr=0, out_valid=0, out_data=0, out_addr=0, out_last=0, index=0, remaining=0.
REQ-033 reset asserted mid-dump SHALL abort the dump with no done pulse; after reset release the block SHALL wait in IDLE for a new start.

Verification
REQ-034 mem[36..39] = 7, 0, 25, 3; base_addr=36, word_count=4; out_ready=1 -> exactly 4 reads at addresses 36..39, outputs (36,7), (37,0), (38,25), (39,3), out_last only with (39,3), done pulse exactly 1 cycle after the last transfer.
REQ-035 Same dump with out_ready low for 5 cycles on word (38,25) -> out_valid, out_data=25, out_addr=38 held stable throughout, no extra reads, and no word lost or duplicated.
REQ-036 ADDR_W=8, base_addr=254, word_count=3 -> out_addr sequence 254, 255, 0.
REQ-037 word_count=0 -> no mem_rd_en, no out_valid; done high in the cycle after start; busy stays 0.
REQ-038 start pulsed during SEND of a 4-word dump -> dump unaffected; reset pulled low during WAIT of word 2 -> all outputs 0 at once, no done; a new start after release runs a full dump correctly.

Source files
------------

// File: rtl/mem_dump.sv
// rtl/mem_dump.sv - streams a contiguous range of memory words out one word per handshake
module mem_dump #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, SEND, FIN} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   index;
  logic [ADDR_W:0]     remaining;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   data_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                last_q;

  // Address wraps naturally because the sum is truncated to ADDR_W bits.
  assign rd_addr = base_q + index;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; a zero-length request skips straight to completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (word_count == '0) ? FIN : REQ;
      REQ:  state_nxt = WAIT;
      WAIT: state_nxt = SEND;
      SEND: if (out_ready) state_nxt = last_q ? FIN : REQ;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Dump parameters and progress counters; start is only honoured in IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      base_q    <= '0;
      index     <= '0;
      remaining <= '0;
    end else if (state == IDLE && start && word_count != '0) begin
      base_q    <= base_addr;
      index     <= '0;
      remaining <= word_count;
    end else if (state == SEND && out_ready) begin
      remaining <= remaining - 1'b1;
      index     <= index + 1'b1;
    end
  end

  // Output word registers load once per word and then hold through any stall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      addr_q <= '0;
      last_q <= 1'b0;
    end else if (state == WAIT) begin
      data_q <= mem_rd_data;
      addr_q <= rd_addr;
      last_q <= (remaining == {{ADDR_W{1'b0}}, 1'b1});
    end
  end

  // Control outputs decoded from state only.
  always_comb begin
    busy      = (state == REQ) || (state == WAIT) || (state == SEND);
    done      = (state == FIN);
    mem_rd_en = (state == REQ);
    mem_addr  = (state == REQ) ? rd_addr : '0;
    out_valid = (state == SEND);
    out_data  = data_q;
    out_addr  = addr_q;
    out_last  = last_q;
  end

endmodule
